// File: rtl/handshake_pkg.sv
// Shared constants and helpers for the handshake_buffer elastic FIFO stage.
package handshake_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int STATS_WIDTH        = 32;

  // Ceiling log2, used to size pointers and the occupancy counter.
  function automatic int clog2(input int value);
    int result;
    int acc;
    result = 0;
    acc    = 1;
    while (acc < value) begin
      acc    = acc * 2;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/handshake_buffer_mem.sv
// Entry storage for handshake_buffer: one write port and one registered read port.
module handshake_buffer_mem
  import handshake_pkg::*;
#(
  parameter int data_width = DEFAULT_DATA_WIDTH,
  parameter int depth      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_we,
  input  logic [clog2(depth)-1:0]   i_waddr,
  input  logic [data_width-1:0]     i_wdata,
  input  logic                      i_re,
  input  logic [clog2(depth)-1:0]   i_raddr,
  output logic [data_width-1:0]     o_rdata
);

  logic [data_width-1:0] r_mem [depth];
  logic [data_width-1:0] r_rdata;

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register holds its value between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= {data_width{1'b0}};
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/handshake_buffer.sv
// Elastic FIFO stage speaking pull req/ack on both sides.
// Optional statistics outputs are enabled by defining HANDSHAKE_BUFFER_STATS_EN.
module handshake_buffer
  import handshake_pkg::*;
#(
  parameter int data_width = DEFAULT_DATA_WIDTH,
  parameter int depth      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    req_l,
  input  logic                    ack_l,
  input  logic [data_width-1:0]   din,
  input  logic                    req_r,
  output logic                    ack_r,
  output logic [data_width-1:0]   dout,
  output logic [clog2(depth):0]   level
`ifdef HANDSHAKE_BUFFER_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0]  count_in,
  output logic [STATS_WIDTH-1:0]  count_out,
  output logic [STATS_WIDTH-1:0]  max_level
`endif
);

  localparam int PTR_W = clog2(depth);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(depth);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [LVL_W-1:0]      r_level;
  logic                  r_req_l;
  logic                  r_ack_r;
  logic                  w_wr;
  logic                  w_rd;
  logic [LVL_W-1:0]      w_level_nxt;
  logic [data_width-1:0] w_rdata;

  // Accept writes only with room; issue a read only when not already acking.
  always_comb begin
    w_wr        = 1'b0;
    w_rd        = 1'b0;
    w_level_nxt = r_level;
    if (ack_l && (r_level != LVL_FULL)) begin
      w_wr = 1'b1;
    end else begin
      w_wr = 1'b0;
    end
    if (req_r && !r_ack_r && (r_level != LVL_ZERO)) begin
      w_rd = 1'b1;
    end else begin
      w_rd = 1'b0;
    end
    case ({w_wr, w_rd})
      2'b10:   w_level_nxt = r_level + LVL_ONE;
      2'b01:   w_level_nxt = r_level - LVL_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  // Pointers, occupancy and handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= PTR_ZERO;
      r_tail  <= PTR_ZERO;
      r_level <= LVL_ZERO;
      r_req_l <= 1'b0;
      r_ack_r <= 1'b0;
    end else begin
      if (w_wr) begin
        r_tail <= r_tail + PTR_ONE;
      end
      if (w_rd) begin
        r_head <= r_head + PTR_ONE;
      end
      r_level <= w_level_nxt;
      r_req_l <= (w_level_nxt != LVL_FULL);
      r_ack_r <= w_rd;
    end
  end

  handshake_buffer_mem #(
    .data_width (data_width),
    .depth      (depth)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr),
    .i_waddr (r_tail),
    .i_wdata (din),
    .i_re    (w_rd),
    .i_raddr (r_head),
    .o_rdata (w_rdata)
  );

  assign req_l = r_req_l;
  assign ack_r = r_ack_r;
  assign dout  = w_rdata;
  assign level = r_level;

`ifdef HANDSHAKE_BUFFER_STATS_EN
  logic [STATS_WIDTH-1:0] r_count_in;
  logic [STATS_WIDTH-1:0] r_count_out;
  logic [STATS_WIDTH-1:0] r_max_level;
  logic [STATS_WIDTH-1:0] w_level_ext;

  assign w_level_ext = {{(STATS_WIDTH-LVL_W){1'b0}}, w_level_nxt};

  // Throughput counters wrap naturally; peak tracks the post-update occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count_in  <= {STATS_WIDTH{1'b0}};
      r_count_out <= {STATS_WIDTH{1'b0}};
      r_max_level <= {STATS_WIDTH{1'b0}};
    end else begin
      if (w_wr) begin
        r_count_in <= r_count_in + 32'd1;
      end
      if (w_rd) begin
        r_count_out <= r_count_out + 32'd1;
      end
      if (w_level_ext > r_max_level) begin
        r_max_level <= w_level_ext;
      end
    end
  end

  assign count_in  = r_count_in;
  assign count_out = r_count_out;
  assign max_level = r_max_level;
`endif

endmodule

// File: tb/tb_handshake_buffer.sv
// Scoreboard bench for handshake_buffer (depth 4, 32-bit payload).
module tb_handshake_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic                     clk   = 1'b0;
  logic                     rst   = 1'b1;
  logic                     ack_l = 1'b0;
  logic                     req_r = 1'b0;
  logic [DW-1:0]            din   = '0;
  logic                     req_l;
  logic                     ack_r;
  logic [DW-1:0]            dout;
  logic [$clog2(DEPTH):0]   level;
`ifdef HANDSHAKE_BUFFER_STATS_EN
  logic [31:0]              count_in;
  logic [31:0]              count_out;
  logic [31:0]              max_level;
`endif

  int            n_checks = 0;
  int            n_fail   = 0;
  int            next_val = 0;
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] exp_v;

  always #5 clk = ~clk;

  handshake_buffer #(.data_width(DW), .depth(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .req_l (req_l),
    .ack_l (ack_l),
    .din   (din),
    .req_r (req_r),
    .ack_r (ack_r),
    .dout  (dout),
    .level (level)
`ifdef HANDSHAKE_BUFFER_STATS_EN
    ,
    .count_in  (count_in),
    .count_out (count_out),
    .max_level (max_level)
`endif
  );

  task automatic push_write();
    ack_l = 1'b1;
    din   = DW'(next_val);
    sb_q.push_back(DW'(next_val));
    next_val++;
  endtask

  task automatic drive_stream(input int n, input int pfail, input int cfail, input string tag);
    int sent  = 0;
    int got   = 0;
    int cyc   = 0;
    int limit = n * 8 + 100;
    while (got < n && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
      if (ack_r === 1'b1) begin
        got++;
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s_extra: got %0h, expected no data", tag, dout);
        end else begin
          exp_v = sb_q.pop_front();
          if (dout !== exp_v) begin
            n_fail++;
            $display("FAIL %s_order: got %0h, expected %0h", tag, dout, exp_v);
          end
        end
      end
      n_checks++;
      if (level > DEPTH) begin
        n_fail++;
        $display("FAIL %s_level_max: got %0d, expected <= %0d", tag, level, DEPTH);
      end
      ack_l = 1'b0;
      if (sent < n && req_l === 1'b1 && $urandom_range(99, 0) >= 32'(pfail)) begin
        n_checks++;
        if (level == DEPTH) begin
          n_fail++;
          $display("FAIL %s_accept_full: got level %0d with req_l high, expected < %0d", tag, level, DEPTH);
        end
        push_write();
        sent++;
      end
      req_r = ($urandom_range(99, 0) >= 32'(cfail));
    end
    ack_l = 1'b0;
    req_r = 1'b0;
    n_checks++;
    if (got != n) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d items, expected %0d", tag, got, n);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    ack_l = 1'b1;
    din   = 32'hDEAD_BEEF;
    #1;
    n_checks += 4;
    if (req_l !== 1'b0) begin n_fail++; $display("FAIL reset_req_l: got %0b, expected 0", req_l); end
    if (ack_r !== 1'b0) begin n_fail++; $display("FAIL reset_ack_r: got %0b, expected 0", ack_r); end
    if (dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout: got %0h, expected 0", dout); end
    if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d, expected 0", level); end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (level !== 3'd0) begin n_fail++; $display("FAIL reset_ack_ignored: got level %0d, expected 0", level); end
    ack_l = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (req_l !== 1'b1) begin n_fail++; $display("FAIL reset_release_req_l: got %0b, expected 1", req_l); end
  endtask

  task automatic test_stream();
    drive_stream(5000, 0, 0, "stream");
    n_checks++;
    if (level !== 3'd0) begin n_fail++; $display("FAIL stream_drained: got level %0d, expected 0", level); end
  endtask

  task automatic test_full();
    int got = 0;
    req_r = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      push_write();
      @(posedge clk); #1;
    end
    ack_l = 1'b0;
    @(posedge clk); #1;
    n_checks += 2;
    if (level !== 3'd4) begin n_fail++; $display("FAIL full_level: got %0d, expected 4", level); end
    if (req_l !== 1'b0) begin n_fail++; $display("FAIL full_req_l: got %0b, expected 0", req_l); end
    req_r = 1'b1;
    for (int c = 0; c < 40 && got < DEPTH; c++) begin
      @(posedge clk); #1;
      if (ack_r === 1'b1) begin
        got++;
        exp_v = sb_q.pop_front();
        n_checks++;
        if (dout !== exp_v) begin n_fail++; $display("FAIL full_order: got %0h, expected %0h", dout, exp_v); end
      end
    end
    req_r = 1'b0;
    n_checks += 3;
    if (got != DEPTH) begin n_fail++; $display("FAIL full_drain_count: got %0d, expected %0d", got, DEPTH); end
    if (req_l !== 1'b1) begin n_fail++; $display("FAIL full_req_l_reassert: got %0b, expected 1", req_l); end
    if (level !== 3'd0) begin n_fail++; $display("FAIL full_drained: got level %0d, expected 0", level); end
  endtask

  task automatic test_simultaneous();
    req_r = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push_write();
      @(posedge clk); #1;
    end
    push_write();
    req_r = 1'b1;
    @(posedge clk); #1;
    ack_l = 1'b0;
    req_r = 1'b0;
    n_checks += 2;
    if (level !== 3'd2) begin n_fail++; $display("FAIL simul_level: got %0d, expected 2", level); end
    if (ack_r !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_ack_r: got %0b, expected 1", ack_r);
    end else begin
      exp_v = sb_q.pop_front();
      n_checks++;
      if (dout !== exp_v) begin n_fail++; $display("FAIL simul_order: got %0h, expected %0h", dout, exp_v); end
    end
    req_r = 1'b1;
    for (int c = 0; c < 40 && sb_q.size() > 0; c++) begin
      @(posedge clk); #1;
      if (ack_r === 1'b1) begin
        exp_v = sb_q.pop_front();
        n_checks++;
        if (dout !== exp_v) begin n_fail++; $display("FAIL simul_drain_order: got %0h, expected %0h", dout, exp_v); end
      end
    end
    req_r = 1'b0;
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL simul_drain_timeout: got %0d left, expected 0", sb_q.size()); end
  endtask

  task automatic test_reset_mid();
    req_r = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_write();
      @(posedge clk); #1;
    end
    ack_l = 1'b0;
    n_checks++;
    if (level !== 3'd3) begin n_fail++; $display("FAIL midrst_prefill: got level %0d, expected 3", level); end
    #2;
    rst = 1'b0;
    #1;
    n_checks += 4;
    if (req_l !== 1'b0) begin n_fail++; $display("FAIL midrst_req_l: got %0b, expected 0", req_l); end
    if (ack_r !== 1'b0) begin n_fail++; $display("FAIL midrst_ack_r: got %0b, expected 0", ack_r); end
    if (dout !== 32'h0) begin n_fail++; $display("FAIL midrst_dout: got %0h, expected 0", dout); end
    if (level !== 3'd0) begin n_fail++; $display("FAIL midrst_level: got %0d, expected 0", level); end
    ack_l = 1'b1;
    din   = 32'h0BAD_0BAD;
    repeat (2) @(posedge clk);
    #1;
    ack_l = 1'b0;
    sb_q.delete();
    n_checks++;
    if (level !== 3'd0) begin n_fail++; $display("FAIL midrst_ack_ignored: got level %0d, expected 0", level); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (req_l !== 1'b1) begin n_fail++; $display("FAIL midrst_req_l_rise: got %0b, expected 1", req_l); end
    drive_stream(6, 0, 0, "midrst_after");
  endtask

  task automatic test_random();
    drive_stream(300, 30, 30, "random");
  endtask

`ifdef HANDSHAKE_BUFFER_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    drive_stream(100, 0, 0, "stats");
    n_checks += 3;
    if (count_in !== 32'd100) begin n_fail++; $display("FAIL stats_count_in: got %0d, expected 100", count_in); end
    if (count_out !== 32'd100) begin n_fail++; $display("FAIL stats_count_out: got %0d, expected 100", count_out); end
    if (max_level > 32'd4 || max_level == 32'd0) begin
      n_fail++;
      $display("FAIL stats_max_level: got %0d, expected 1..4", max_level);
    end
  endtask
`endif

  initial begin
    #2;
    test_reset();
    test_stream();
    test_full();
    test_simultaneous();
    test_reset_mid();
    test_random();
`ifdef HANDSHAKE_BUFFER_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/handshake_buffer.md
HANDSHAKE_BUFFER -- requirements
Module: handshake_buffer

Interface
REQ-001 Parameter data_width, default 32, payload width in bits.
REQ-002 Parameter depth, default 4, entry count; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_l  output  1  request to upstream stage (operator/producer side).
REQ-006 ack_l  input  1  one-cycle upstream acknowledge; din valid in the same cycle.
REQ-007 din  input  data_width  upstream payload.
REQ-008 req_r  input  1  request from downstream stage (consumer/operator side).
REQ-009 ack_r  output  1  one-cycle acknowledge to downstream; dout valid in the same cycle.
REQ-010 dout  output  data_width  downstream payload.
REQ-011 level  output  $clog2(depth)+1  current occupancy.

Function
REQ-012 The block SHALL be an elastic FIFO stage inserted between an async_operator output and its consumer, speaking the pull req/ack protocol on both sides.
REQ-013 Write: on a cycle with ack_l=1, din SHALL be stored at the tail, and occupancy SHALL increment.
REQ-014 req_l SHALL be registered, with next value = 1 iff free slots after the current cycle's write/read >= 1.
REQ-015 With depth >= 1 free at any time, an ack_l arriving while full is impossible; if it occurs anyway, the write SHALL be dropped and occupancy SHALL be unchanged.
REQ-016 Read: if req_r=1, ack_r=0 and occupancy > 0, then next cycle ack_r=1, dout=head entry, and occupancy SHALL decrement; otherwise ack_r=0 next cycle.
REQ-017 Read latency SHALL be 1 cycle from a sampled req_r to ack_r; sustained read rate SHALL be at most one item per 2 cycles.
REQ-018 dout SHALL hold its last value when ack_r=0.
REQ-019 A simultaneous write and read SHALL both complete, leaving occupancy unchanged.
REQ-020 An empty FIFO with a write in cycle t SHALL allow ack_r with that data no earlier than t+2 (no bypass).
REQ-021 Head and tail pointers SHALL wrap modulo depth; data order SHALL be strictly FIFO.
REQ-022 level SHALL equal writes minus reads since reset and SHALL range 0..depth.

Reset
REQ-023 Asserting rst low SHALL immediately force req_l=0, ack_r=0, dout=0, level=0, and both pointers to 0, and SHALL clear all stats counters.
REQ-024 Any ack_l present during reset SHALL be ignored; stored entries SHALL be discarded.
REQ-025 After release, req_l SHALL rise on the first clock edge.

Configuration
REQ-026 Macro HANDSHAKE_BUFFER_STATS_EN defined: the block SHALL add 32-bit outputs count_in (accepted writes), count_out (issued acks) and max_level (peak occupancy), all reset to 0, with counters wrapping at 2^32.
REQ-027 Macro undefined: these ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Package handshake_pkg SHALL hold the default data width, the pointer-width helper (clog2), and the stats counter width constant of 32.
REQ-029 Storage SHALL be one sub-module, handshake_buffer_mem: depth x data_width register array with one write port and one registered read port.

Verification
REQ-030 Scenario: depth=4, producer incrementing from 0 and consumer both at fail_rate 0, 5000 items -> consumer receives 0..4999 in order and level never exceeds 4.
REQ-031 Scenario: consumer req_r held 0 -> after 4 writes level=4 and req_l=0; release req_r -> ack_r returns 0,1,2,3 and req_l reasserts.
REQ-032 Scenario: simultaneous ack_l and read at level=2 -> level stays 2 and the data sequence is uninterrupted.
REQ-033 Scenario: rst pulled low mid-stream with level=3 -> outputs 0 within the same cycle; after release, the first ack_r data is the next produced value (no stale entries).
REQ-034 Scenario: producer and consumer at fail_rate 30 -> stream is ordered and lossless, with no ack_l accepted at level=depth.
REQ-035 Scenario: with HANDSHAKE_BUFFER_STATS_EN, 100 items passed -> count_in=100, count_out=100, max_level<=4.
